wb_port_arbiter: RTL and testbench

- Owns the single register-file write port and shares it between two requesters: the in-order pipeline writeback (WB stage output) and a multi-cycle multiply/divide unit (MDU) whose results retire out of order.
- The pipeline has priority. MDU results are held in a small FIFO and drained into idle WB slots.
- A starvation guard can stall the pipeline for one cycle to force a drain.
- Write-port outputs are registered and drive the register file directly.

---
 rtl/wb_port_arbiter_pkg.sv | 16 +
 rtl/wb_arb_fifo.sv | 53 +++++
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default widths,
// the hardwired zero register, and the grant-source encoding.
package wb_port_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_PIPE   = 2'd1,
    GNT_FIFO   = 2'd2,
    GNT_BYPASS = 2'd3
  } gnt_src_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO holding MDU results that lost the write port.
// Pushes into a full FIFO are ignored, even when a pop happens in the same cycle.
module wb_arb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap modulo DEPTH so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)
        count <= count + CNT_W'(1);
      else if (do_pop && !do_push)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback and MDU results.
// Define WB_ARB_STARVE_GUARD_EN to enable the starvation guard that stalls the pipeline for a drain.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_wb_en,
  input  logic [ADDR_W-1:0]          pipe_wb_addr,
  input  logic [DATA_W-1:0]          pipe_wb_data,
  output logic                       pipe_stall,
  input  logic                       mdu_valid,
  input  logic [ADDR_W-1:0]          mdu_addr,
  input  logic [DATA_W-1:0]          mdu_data,
  output logic                       mdu_ready,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic             pipe_busy;
  logic             mdu_live;
  logic             starve;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  gnt_src_e         gnt;

  assign pipe_busy = pipe_wb_en && (pipe_wb_addr != ADDR_W'(REG_ZERO));
  assign mdu_ready = !rst && (fifo_count < CNT_W'(DEPTH));
  assign mdu_live  = mdu_valid && mdu_ready && (mdu_addr != ADDR_W'(REG_ZERO));

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT+1);
  logic [WAIT_W-1:0] wait_cnt;

  assign starve = (wait_cnt == WAIT_W'(MAX_WAIT)) && (fifo_count != '0);

  // Counts cycles a non-empty FIFO has gone without a pop.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (pop || fifo_count == '0)
      wait_cnt <= '0;
    else if (wait_cnt != WAIT_W'(MAX_WAIT))
      wait_cnt <= wait_cnt + WAIT_W'(1);
  end
`else
  // Guard compiled out: the FIFO only drains in idle pipeline slots.
  assign starve = (MAX_WAIT < 0);
`endif

  assign pipe_stall = !rst && starve && pipe_busy;

  always_comb begin
    gnt = GNT_NONE;
    if (starve)
      gnt = GNT_FIFO;
    else if (pipe_busy)
      gnt = GNT_PIPE;
    else if (fifo_count != '0)
      gnt = GNT_FIFO;
    else if (mdu_live)
      gnt = GNT_BYPASS;
  end

  assign pop  = (gnt == GNT_FIFO);
  assign push = mdu_live && (gnt != GNT_BYPASS);

  wb_arb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mdu_addr, mdu_data}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (gnt != GNT_NONE);
      case (gnt)
        GNT_PIPE: begin
          rf_waddr <= pipe_wb_addr;
          rf_wdata <= pipe_wb_data;
        end
        GNT_FIFO: begin
          rf_waddr <= head[ENT_W-1:DATA_W];
          rf_wdata <= head[DATA_W-1:0];
        end
        GNT_BYPASS: begin
          rf_waddr <= mdu_addr;
          rf_wdata <= mdu_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=8).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [4:0]  pipe_wb_addr;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;

  int passed = 0;
  int total  = 0;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .MAX_WAIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_wb_en   (pipe_wb_en),
    .pipe_wb_addr (pipe_wb_addr),
    .pipe_wb_data (pipe_wb_data),
    .pipe_stall   (pipe_stall),
    .mdu_valid    (mdu_valid),
    .mdu_addr     (mdu_addr),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wb_en = 1'b0; pipe_wb_addr = 5'd0; pipe_wb_data = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pipe_wb_en = 1'b1; pipe_wb_addr = 5'd3; pipe_wb_data = 32'h55;
    #1;
    total++; if (mdu_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %0b expected 0", mdu_ready); else passed++;
    cycle();
    total++; if (pipe_stall !== 1'b0) $display("[TB] FAIL rst_stall: got %0b expected 0", pipe_stall); else passed++;
    total++; if (rf_we !== 1'b0) $display("[TB] FAIL rst_we: got %0b expected 0", rf_we); else passed++;
    total++; if (rf_waddr !== 5'd0) $display("[TB] FAIL rst_waddr: got %0h expected 0", rf_waddr); else passed++;
    total++; if (rf_wdata !== 32'd0) $display("[TB] FAIL rst_wdata: got %0h expected 0", rf_wdata); else passed++;
    total++; if (fifo_count !== 2'd0) $display("[TB] FAIL rst_count: got %0d expected 0", fifo_count); else passed++;
    rst = 1'b0;
    idle();
    cycle();
  endtask

  task automatic test_pipe_only();
    for (int i = 0; i < 3; i++) begin
      pipe_wb_en = 1'b1; pipe_wb_addr = 5'd3; pipe_wb_data = 32'h11;
      cycle();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11)
        $display("[TB] FAIL pipe_write: got we=%0b a=%0d d=%0h expected we=1 a=3 d=11", rf_we, rf_waddr, rf_wdata); else passed++;
      total++; if (mdu_ready !== 1'b1 || fifo_count !== 2'd0)
        $display("[TB] FAIL pipe_fifo: got ready=%0b count=%0d expected ready=1 count=0", mdu_ready, fifo_count); else passed++;
    end
    idle();
    cycle();
    total++; if (rf_we !== 1'b0) $display("[TB] FAIL pipe_idle_we: got %0b expected 0", rf_we); else passed++;
  endtask

  task automatic test_bypass();
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'hABCD;
    #1;
    total++; if (mdu_ready !== 1'b1) $display("[TB] FAIL byp_ready: got %0b expected 1", mdu_ready); else passed++;
    cycle();
    idle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hABCD)
      $display("[TB] FAIL byp_write: got we=%0b a=%0d d=%0h expected we=1 a=7 d=abcd", rf_we, rf_waddr, rf_wdata); else passed++;
    total++; if (fifo_count !== 2'd0) $display("[TB] FAIL byp_count: got %0d expected 0", fifo_count); else passed++;
    cycle();
    total++; if (rf_we !== 1'b0) $display("[TB] FAIL byp_after_we: got %0b expected 0", rf_we); else passed++;
  endtask

  task automatic test_collision();
    pipe_wb_en = 1'b1; pipe_wb_addr = 5'd4; pipe_wb_data = 32'h4;
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h9;
    cycle();
    idle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h4)
      $display("[TB] FAIL col_pipe: got we=%0b a=%0d d=%0h expected we=1 a=4 d=4", rf_we, rf_waddr, rf_wdata); else passed++;
    total++; if (fifo_count !== 2'd1) $display("[TB] FAIL col_count1: got %0d expected 1", fifo_count); else passed++;
    cycle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9)
      $display("[TB] FAIL col_drain: got we=%0b a=%0d d=%0h expected we=1 a=9 d=9", rf_we, rf_waddr, rf_wdata); else passed++;
    total++; if (fifo_count !== 2'd0) $display("[TB] FAIL col_count0: got %0d expected 0", fifo_count); else passed++;
  endtask

  task automatic test_full();
    pipe_wb_en = 1'b1; pipe_wb_addr = 5'd1; pipe_wb_data = 32'h100;
    mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'hA;
    cycle();
    mdu_addr = 5'd11; mdu_data = 32'hB;
    cycle();
    total++; if (fifo_count !== 2'd2) $display("[TB] FAIL full_count: got %0d expected 2", fifo_count); else passed++;
    mdu_addr = 5'd12; mdu_data = 32'hC;
    #1;
    total++; if (mdu_ready !== 1'b0) $display("[TB] FAIL full_ready: got %0b expected 0", mdu_ready); else passed++;
    cycle();
    total++; if (fifo_count !== 2'd2 || rf_waddr !== 5'd1)
      $display("[TB] FAIL full_hold: got count=%0d a=%0d expected count=2 a=1", fifo_count, rf_waddr); else passed++;
    pipe_wb_en = 1'b0;
    cycle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA || fifo_count !== 2'd1)
      $display("[TB] FAIL full_drain0: got a=%0d d=%0h count=%0d expected a=10 d=a count=1", rf_waddr, rf_wdata, fifo_count); else passed++;
    total++; if (mdu_ready !== 1'b1) $display("[TB] FAIL full_ready_again: got %0b expected 1", mdu_ready); else passed++;
    cycle();
    mdu_valid = 1'b0;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hB || fifo_count !== 2'd1)
      $display("[TB] FAIL full_drain1: got a=%0d d=%0h count=%0d expected a=11 d=b count=1", rf_waddr, rf_wdata, fifo_count); else passed++;
    cycle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC || fifo_count !== 2'd0)
      $display("[TB] FAIL full_drain2: got a=%0d d=%0h count=%0d expected a=12 d=c count=0", rf_waddr, rf_wdata, fifo_count); else passed++;
    idle();
    cycle();
  endtask

  task automatic test_starvation();
    pipe_wb_en = 1'b1; pipe_wb_addr = 5'd2; pipe_wb_data = 32'h22;
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h55;
    cycle();
    mdu_valid = 1'b0;
`ifdef WB_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 8; i++) begin
      total++; if (pipe_stall !== 1'b0) $display("[TB] FAIL starve_early: cycle %0d got %0b expected 0", i, pipe_stall); else passed++;
      cycle();
    end
    total++; if (pipe_stall !== 1'b1) $display("[TB] FAIL starve_stall: got %0b expected 1", pipe_stall); else passed++;
    cycle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55 || fifo_count !== 2'd0)
      $display("[TB] FAIL starve_pop: got a=%0d d=%0h count=%0d expected a=5 d=55 count=0", rf_waddr, rf_wdata, fifo_count); else passed++;
    total++; if (pipe_stall !== 1'b0) $display("[TB] FAIL starve_one_cycle: got %0b expected 0", pipe_stall); else passed++;
    cycle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22)
      $display("[TB] FAIL starve_resume: got a=%0d d=%0h expected a=2 d=22", rf_waddr, rf_wdata); else passed++;
`else
    for (int i = 0; i < 12; i++) begin
      total++; if (pipe_stall !== 1'b0 || fifo_count !== 2'd1)
        $display("[TB] FAIL nostarve: cycle %0d got stall=%0b count=%0d expected stall=0 count=1", i, pipe_stall, fifo_count); else passed++;
      cycle();
      total++; if (rf_waddr !== 5'd2) $display("[TB] FAIL nostarve_pipe: got a=%0d expected 2", rf_waddr); else passed++;
    end
    pipe_wb_en = 1'b0;
    cycle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55 || fifo_count !== 2'd0)
      $display("[TB] FAIL nostarve_drain: got a=%0d d=%0h count=%0d expected a=5 d=55 count=0", rf_waddr, rf_wdata, fifo_count); else passed++;
`endif
    idle();
    cycle();
  endtask

  task automatic test_zero_reg();
    pipe_wb_en = 1'b1; pipe_wb_addr = 5'd0; pipe_wb_data = 32'hDEAD;
    cycle();
    total++; if (rf_we !== 1'b0) $display("[TB] FAIL zero_pipe: got %0b expected 0", rf_we); else passed++;
    pipe_wb_en = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'hBEEF;
    #1;
    total++; if (mdu_ready !== 1'b1) $display("[TB] FAIL zero_ready: got %0b expected 1", mdu_ready); else passed++;
    cycle();
    total++; if (rf_we !== 1'b0 || fifo_count !== 2'd0)
      $display("[TB] FAIL zero_mdu: got we=%0b count=%0d expected we=0 count=0", rf_we, fifo_count); else passed++;
    pipe_wb_en = 1'b1; pipe_wb_addr = 5'd6; pipe_wb_data = 32'h66;
    cycle();
    total++; if (fifo_count !== 2'd0 || rf_waddr !== 5'd6)
      $display("[TB] FAIL zero_mdu_busy: got count=%0d a=%0d expected count=0 a=6", fifo_count, rf_waddr); else passed++;
    idle();
    cycle();
  endtask

  task automatic test_reset_mid();
    pipe_wb_en = 1'b1; pipe_wb_addr = 5'd8; pipe_wb_data = 32'h88;
    mdu_valid = 1'b1; mdu_addr = 5'd13; mdu_data = 32'hD;
    cycle();
    mdu_addr = 5'd14; mdu_data = 32'hE;
    cycle();
    mdu_valid = 1'b0;
    total++; if (fifo_count !== 2'd2) $display("[TB] FAIL mid_fill: got %0d expected 2", fifo_count); else passed++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle();
    total++; if (rf_we !== 1'b0 || fifo_count !== 2'd0)
      $display("[TB] FAIL mid_rst: got we=%0b count=%0d expected we=0 count=0", rf_we, fifo_count); else passed++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (rf_we !== 1'b0 || fifo_count !== 2'd0)
        $display("[TB] FAIL mid_stale: cycle %0d got we=%0b count=%0d expected we=0 count=0", i, rf_we, fifo_count); else passed++;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_pipe_only();
    test_bypass();
    test_collision();
    test_full();
    test_starvation();
    test_zero_reg();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
